alu_bist_ctrl: RTL and testbench
================================

Name: alu_bist_ctrl

Overview:
- Hardware self-test controller for the 16-bit, 8-operation ALU: the stimulus/checker end of the ALU operand/result interface.
- Generates pseudo-random {a, b, cin} vectors, sweeps all 3-bit operators, and drives one shared vector to a reference ALU and a DUT ALU instance.
- Compares result word, zero flag and negative flag on every vector; counts mismatches and captures the first failing vector.
- Sits beside the ALU pair in the datapath test wrapper; replaces simulation-only random checking with an on-chip equivalent.

Parameters:
- WIDTH, 16, ALU operand/result width.
- OP_W, 3, operator width; all 2**OP_W operators are swept.
- VEC_PER_OP, 10, vectors applied per operator.
- SEED, 33'h1_ACE1_BEEF, LFSR reset/start value; must be nonzero.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin run; sampled in IDLE or DONE only.
- abort  in  1  synchronous return to IDLE; done is not asserted.
- alu_a  out  WIDTH  operand A to both ALUs.
- alu_b  out  WIDTH  operand B to both ALUs.
- alu_cin  out  1  carry in to both ALUs.
- alu_op  out  OP_W  operator to both ALUs.
- ref_w / dut_w  in  WIDTH  results from the reference and DUT ALUs.
- ref_z / dut_z  in  1  zero flags.
- ref_n / dut_n  in  1  negative flags.
- busy  out  1  high in APPLY/CHECK.
- done  out  1  level, high in DONE until the next start.
- pass  out  1  done && err_count==0.
- err_count  out  16  mismatching vectors; saturates at 16'hFFFF.
- fail_valid  out  1  first failure captured.
- fail_op / fail_a / fail_b / fail_cin  out  OP_W/WIDTH/WIDTH/1  first failing vector.

Behaviour:
- Reset: state=IDLE; lfsr=SEED; op_cnt=0; vec_cnt=0; all outputs 0.
- States:
  - IDLE: on start -> APPLY; clears err_count and fail_*; loads lfsr=SEED, op_cnt=0, vec_cnt=0.
  - APPLY: alu_* are registered; alu_a=lfsr[32:17], alu_b=lfsr[16:1], alu_cin=lfsr[0], alu_op=op_cnt. One full cycle lets the combinational ALUs settle. Always -> CHECK.
  - CHECK: at the closing edge, compares ref vs dut. Mismatch = (ref_w!=dut_w)|(ref_z!=dut_z)|(ref_n!=dut_n).
    - On mismatch: err_count++ (saturating). If !fail_valid, captures the alu_* values and sets fail_valid.
    - LFSR steps once per vector.
    - vec_cnt increments; at VEC_PER_OP-1 it wraps to 0 and op_cnt increments.
    - After the last vector of op 2**OP_W-1 -> DONE; otherwise -> APPLY.
  - DONE: done=1, outputs hold. start -> same actions as from IDLE.
- LFSR: 33-bit Fibonacci, polynomial x^33+x^20+1. Shift left, new bit0 = lfsr[32]^lfsr[19]. The first vector uses SEED unshifted. The LFSR is not reloaded between operators.
- Timing: 2 cycles per vector. With defaults, done rises 160 cycles after the start edge.
- start while busy is ignored.
- abort has priority over start and over the CHECK update in the same cycle.
- err_count and fail_* survive abort until the next start.
- rst_n low mid-run forces the reset values immediately.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, APPLY, CHECK, DONE);
  - LFSR width 33 and tap positions;
  - WIDTH/OP_W defaults used by the ALU.
- One sub-module: bist_lfsr33, with ports clk, rst_n, load, step, seed, q.

Test Plan:
- dut tied to a second copy of the reference ALU, start pulse -> busy 160 cycles; done=1, pass=1, err_count=0, fail_valid=0.
- dut_w = ~ref_w -> err_count=80, pass=0; fail_op=0, fail_a=SEED[32:17], fail_b=SEED[16:1], fail_cin=SEED[0].
- dut_z inverted only when alu_op==5 -> err_count=10, fail_op=5.
- start re-pulsed at cycle 40 of a run -> ignored; done still at cycle 160. After done, a new start -> err_count cleared and an identical vector sequence.
- rst_n low at cycle 50 -> busy=0, alu_*=0, err_count=0 immediately. Release and start -> first vector equals SEED.
- abort asserted during CHECK with a mismatch present -> IDLE next cycle, err_count unchanged, done=0.

Source files
------------

// File: rtl/alu_bist_ctrl_pkg.sv
// Shared definitions for the ALU self-test controller.
// Holds the FSM state encoding, the LFSR geometry and the ALU width
// defaults used by both the controller and its LFSR.
package alu_bist_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } bist_state_t;

    // x^33 + x^20 + 1, Fibonacci form: feedback = q[32] ^ q[19]
    localparam int LFSR_W     = 33;
    localparam int LFSR_TAP_A = 32;
    localparam int LFSR_TAP_B = 19;

    localparam logic [LFSR_W-1:0] LFSR_SEED_DEF = 33'h1_ACE1_BEEF;

    localparam int ALU_WIDTH = 16;
    localparam int ALU_OP_W  = 3;

endpackage

// File: rtl/alu_bist_ctrl_lfsr.sv
// 33-bit Fibonacci LFSR that sources the BIST operand vectors.
// Ports:
//   clk, rst_n : clock, async active-low reset (resets q to SEED)
//   load       : q <= seed (wins over step)
//   step       : shift left one position, new bit0 = q[32] ^ q[19]
//   seed       : value loaded on load
//   q          : current LFSR state
module bist_lfsr33
    import alu_bist_ctrl_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = LFSR_SEED_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= SEED;
        end else if (load) begin
            q <= seed;
        end else if (step) begin
            q <= {q[LFSR_W-2:0], q[LFSR_TAP_A] ^ q[LFSR_TAP_B]};
        end
    end

endmodule

// File: rtl/alu_bist_ctrl.sv
// On-chip self-test controller for a reference/DUT ALU pair.
// Drives one pseudo-random {a, b, cin} vector per APPLY/CHECK pair to both
// ALUs, sweeping every operator VEC_PER_OP times, and compares result word,
// zero flag and negative flag.
// Ports:
//   clk, rst_n, start, abort           : control
//   alu_a/alu_b/alu_cin/alu_op         : shared vector to both ALUs
//   ref_w/z/n, dut_w/z/n               : ALU responses
//   busy, done, pass, err_count        : run status
//   fail_valid, fail_op/a/b/cin        : first failing vector
//
// state | meaning
// IDLE  | waiting for start
// APPLY | register next vector onto alu_*
// CHECK | ALUs settled; compare at closing edge, step LFSR/counters
// DONE  | sweep complete, results held until next start
module alu_bist_ctrl
    import alu_bist_ctrl_pkg::*;
#(
    parameter int                WIDTH      = ALU_WIDTH,
    parameter int                OP_W       = ALU_OP_W,
    parameter int                VEC_PER_OP = 10,
    parameter logic [LFSR_W-1:0] SEED       = LFSR_SEED_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_cin,
    output logic [OP_W-1:0]  alu_op,
    input  logic [WIDTH-1:0] ref_w,
    input  logic [WIDTH-1:0] dut_w,
    input  logic             ref_z,
    input  logic             dut_z,
    input  logic             ref_n,
    input  logic             dut_n,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      err_count,
    output logic             fail_valid,
    output logic [OP_W-1:0]  fail_op,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b,
    output logic             fail_cin
);

    localparam int               VEC_W    = $clog2(VEC_PER_OP);
    localparam logic [VEC_W-1:0] VEC_LAST = VEC_W'(VEC_PER_OP - 1);
    localparam logic [OP_W-1:0]  OP_LAST  = {OP_W{1'b1}};

    bist_state_t       state;
    logic [OP_W-1:0]   op_cnt;
    logic [VEC_W-1:0]  vec_cnt;
    logic [LFSR_W-1:0] lfsr;

    logic        mismatch;
    logic [15:0] err_next;
    logic        last_vec;
    logic        start_ok;
    logic        lfsr_step;

    always_comb begin
        mismatch  = (ref_w != dut_w) || (ref_z != dut_z) || (ref_n != dut_n);
        err_next  = err_count;
        if (mismatch && (err_count != 16'hFFFF)) begin
            err_next = err_count + 16'd1;
        end
        last_vec  = (vec_cnt == VEC_LAST) && (op_cnt == OP_LAST);
        // abort outranks both start and the CHECK-edge update
        start_ok  = start && !abort && ((state == ST_IDLE) || (state == ST_DONE));
        lfsr_step = !abort && (state == ST_CHECK);
    end

    bist_lfsr33 #(.SEED(SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (start_ok),
        .step  (lfsr_step),
        .seed  (SEED),
        .q     (lfsr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            op_cnt     <= '0;
            vec_cnt    <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_cin    <= 1'b0;
            alu_op     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_op    <= '0;
            fail_a     <= '0;
            fail_b     <= '0;
            fail_cin   <= 1'b0;
        end else if (abort) begin
            // error record is kept for inspection until the next start
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            pass  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state      <= ST_APPLY;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        op_cnt     <= '0;
                        vec_cnt    <= '0;
                        err_count  <= '0;
                        fail_valid <= 1'b0;
                        fail_op    <= '0;
                        fail_a     <= '0;
                        fail_b     <= '0;
                        fail_cin   <= 1'b0;
                    end
                end
                ST_APPLY: begin
                    alu_a   <= lfsr[LFSR_W-1 -: WIDTH];
                    alu_b   <= lfsr[WIDTH:1];
                    alu_cin <= lfsr[0];
                    alu_op  <= op_cnt;
                    state   <= ST_CHECK;
                end
                ST_CHECK: begin
                    err_count <= err_next;
                    if (mismatch && !fail_valid) begin
                        fail_valid <= 1'b1;
                        fail_op    <= alu_op;
                        fail_a     <= alu_a;
                        fail_b     <= alu_b;
                        fail_cin   <= alu_cin;
                    end
                    if (vec_cnt == VEC_LAST) begin
                        vec_cnt <= '0;
                        op_cnt  <= op_cnt + 1'b1;
                    end else begin
                        vec_cnt <= vec_cnt + 1'b1;
                    end
                    if (last_vec) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == 16'd0);
                    end else begin
                        state <= ST_APPLY;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_bist_ctrl.sv
// Self-checking bench for alu_bist_ctrl: behavioural ALU pair with
// selectable fault injection, plus a vector-list model of the sweep.
module tb_alu_bist_ctrl;

    localparam logic [32:0] SEED = 33'h1_ACE1_BEEF;
    localparam int          NVEC = 80;
    localparam int          RUN  = 160;

    logic        clk = 1'b0;
    logic        rst_n, start, abort;
    logic [15:0] alu_a, alu_b, ref_w, dut_w;
    logic        alu_cin, ref_z, dut_z, ref_n, dut_n;
    logic [2:0]  alu_op, fail_op;
    logic        busy, done, pass, fail_valid, fail_cin;
    logic [15:0] err_count, fail_a, fail_b;

    int          fault_mode;
    logic [3:0]  fault_nib;

    logic [15:0] m_a   [NVEC];
    logic [15:0] m_b   [NVEC];
    logic        m_cin [NVEC];
    logic [2:0]  m_op  [NVEC];

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_bist_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_op(alu_op),
        .ref_w(ref_w), .dut_w(dut_w), .ref_z(ref_z), .dut_z(dut_z),
        .ref_n(ref_n), .dut_n(dut_n),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .fail_valid(fail_valid), .fail_op(fail_op), .fail_a(fail_a),
        .fail_b(fail_b), .fail_cin(fail_cin)
    );

    function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [15:0] a,
                                           input logic [15:0] b, input logic c);
        case (op)
            3'd0:    return a + b + 16'(c);
            3'd1:    return a - b - 16'(c);
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a << b[3:0];
            3'd6:    return a >> b[3:0];
            default: return ~a;
        endcase
    endfunction

    always_comb begin
        ref_w = alu_fn(alu_op, alu_a, alu_b, alu_cin);
        ref_z = (ref_w == 16'd0);
        ref_n = ref_w[15];
        dut_w = ref_w;
        if (fault_mode == 1) dut_w = ~ref_w;
        if (fault_mode == 3 && alu_a[3:0] == fault_nib) dut_w = ref_w ^ 16'h0001;
        dut_z = ref_z ^ ((fault_mode == 2) && (alu_op == 3'd5));
        dut_n = ref_n;
    end

    function automatic logic fault_hit(input int k);
        case (fault_mode)
            1:       return 1'b1;
            2:       return m_op[k] == 3'd5;
            3:       return m_a[k][3:0] == fault_nib;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic build_model();
        logic [32:0] l;
        l = SEED;
        for (int k = 0; k < NVEC; k++) begin
            m_a[k]   = l[32:17];
            m_b[k]   = l[16:1];
            m_cin[k] = l[0];
            m_op[k]  = 3'(k / 10);
            l = {l[31:0], l[32] ^ l[19]};
        end
    endtask

    // One start..done sweep. repulse_at: cycle after which start is raised
    // for one edge (0 = none). abort_at: odd cycle (CHECK) after which abort
    // is raised for one edge (0 = none).
    task automatic run_check(input int repulse_at, input int abort_at);
        int exp_err;
        int first;
        int part;
        exp_err = 0;
        first   = -1;
        for (int k = 0; k < NVEC; k++) begin
            if (fault_hit(k)) begin
                exp_err++;
                if (first < 0) first = k;
            end
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
        chk("err_cleared", 64'(err_count), 64'd0);
        chk("fail_valid_cleared", 64'(fail_valid), 64'd0);
        for (int c = 1; c <= RUN; c++) begin
            @(posedge clk); #1;
            if (abort_at != 0 && c == abort_at + 1) begin
                abort = 1'b0;
                part = 0;
                for (int k = 0; k < (abort_at - 1) / 2; k++)
                    if (fault_hit(k)) part++;
                chk("abort_busy", 64'(busy), 64'd0);
                chk("abort_done", 64'(done), 64'd0);
                chk("abort_err_kept", 64'(err_count), 64'(part));
                @(posedge clk); #1;
                chk("abort_stays_idle", 64'({busy, done}), 64'd0);
                return;
            end
            chk("busy", 64'(busy), 64'(c < RUN));
            chk("done", 64'(done), 64'(c >= RUN));
            if (c % 2 == 1) begin
                chk("vector", 64'({alu_op, alu_a, alu_b, alu_cin}),
                    64'({m_op[(c-1)/2], m_a[(c-1)/2], m_b[(c-1)/2], m_cin[(c-1)/2]}));
            end
            start = (c == repulse_at);
            abort = (c == abort_at);
        end
        start = 1'b0;
        chk("err_count", 64'(err_count), 64'(exp_err));
        chk("pass", 64'(pass), 64'(exp_err == 0));
        chk("fail_valid", 64'(fail_valid), 64'(exp_err != 0));
        if (first >= 0)
            chk("fail_vector", 64'({fail_op, fail_a, fail_b, fail_cin}),
                64'({m_op[first], m_a[first], m_b[first], m_cin[first]}));
        else
            chk("fail_vector", 64'({fail_op, fail_a, fail_b, fail_cin}), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        fault_mode = 0;
        fault_nib  = 4'd0;
        build_model();

        repeat (3) @(posedge clk);
        #1;
        chk("rst_status", 64'({busy, done, pass, fail_valid}), 64'd0);
        chk("rst_err", 64'(err_count), 64'd0);
        chk("rst_alu", 64'({alu_op, alu_a, alu_b, alu_cin}), 64'd0);
        chk("rst_fail", 64'({fail_op, fail_a, fail_b, fail_cin}), 64'd0);
        rst_n = 1'b1;
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;

        fault_mode = 0; run_check(0, 0);
        fault_mode = 1; run_check(0, 0);
        chk("inv_w_first_is_seed", 64'({fail_a, fail_b, fail_cin}), 64'(SEED));
        fault_mode = 2; run_check(40, 0);
        chk("op5_fail_op", 64'(fail_op), 64'd5);
        fault_mode = 0; run_check(0, 0);

        for (int i = 0; i < 2; i++) begin
            fault_nib  = 4'($urandom_range(0, 15));
            fault_mode = 3;
            repeat ($urandom_range(0, 5)) @(posedge clk);
            #1;
            run_check(0, 0);
        end

        fault_mode = 1;
        run_check(0, 2 * $urandom_range(1, 79) + 1);
        chk("abort_fail_kept", 64'(fail_valid), 64'd1);

        // reset mid-run with errors already counted
        fault_mode = 1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (50) @(posedge clk);
        #2;
        chk("pre_rst_err_nonzero", 64'(err_count != 16'd0), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_alu", 64'({alu_op, alu_a, alu_b, alu_cin}), 64'd0);
        chk("midrst_err", 64'(err_count), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        fault_mode = 0;
        @(posedge clk); #1;
        run_check(0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
